// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the IF stage: FSM state type, NOP encoding, PC step and default widths.
package if_fetch_stage_pkg;

  localparam int unsigned DEFAULT_PC_WIDTH    = 32;
  localparam int unsigned DEFAULT_INSTR_WIDTH = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_INCR   = 4;

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request bundle: the fetch stage is master, the memory is slave.
interface if_fetch_stage_if
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEFAULT_INSTR_WIDTH
);

  logic                   Imem_Req;
  logic [PC_WIDTH-1:0]    Imem_Addr;
  logic                   Imem_Ready;
  logic [INSTR_WIDTH-1:0] Imem_Data;

  modport master (
    output Imem_Req,
    output Imem_Addr,
    input  Imem_Ready,
    input  Imem_Data
  );

  modport slave (
    input  Imem_Req,
    input  Imem_Addr,
    output Imem_Ready,
    output Imem_Data
  );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load / bubble / flush / hold controls.
module if_fetch_stage_if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   bubble,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    IF_ID_PC,
  output logic [INSTR_WIDTH-1:0] IF_ID_Instr,
  output logic                   IF_ID_Valid
);

  // Bubble and flush both invalidate the slot but leave the PC field alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_PC    <= '0;
      IF_ID_Instr <= INSTR_WIDTH'(NOP_INSTR);
      IF_ID_Valid <= 1'b0;
    end else if (flush || bubble) begin
      IF_ID_Instr <= INSTR_WIDTH'(NOP_INSTR);
      IF_ID_Valid <= 1'b0;
    end else if (load) begin
      IF_ID_PC    <= pc;
      IF_ID_Instr <= instr;
      IF_ID_Valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC register, imem request FSM (FETCH/HOLD/DRAIN) and IF/ID register.
// Define IF_FETCH_STALL_CNT_EN to add saturating Stall_Cycles / Bubble_Cycles counters.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int unsigned         INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PC_Write,
  input  logic                   IF_ID_Write,
  input  logic                   Flush,
  input  logic [PC_WIDTH-1:0]    Branch_Target,
  if_fetch_stage_if.master       imem,
  output logic [PC_WIDTH-1:0]    IF_ID_PC,
  output logic [INSTR_WIDTH-1:0] IF_ID_Instr,
  output logic                   IF_ID_Valid,
`ifdef IF_FETCH_STALL_CNT_EN
  output logic [31:0]            Stall_Cycles,
  output logic [31:0]            Bubble_Cycles,
`endif
  output logic                   Fetch_Busy
);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    tgt_q, tgt_d;
  logic [INSTR_WIDTH-1:0] buf_q, buf_d;
  logic                   req_q, req_d;

  logic                   advance;
  logic                   ready;
  logic                   ifid_load;
  logic                   ifid_bubble;
  logic                   fetch_bubble;
  logic [INSTR_WIDTH-1:0] ifid_instr;
  logic [PC_WIDTH-1:0]    pc_next;

  assign advance = PC_Write & IF_ID_Write;
  // Ready only counts once a request has actually been presented.
  assign ready   = req_q & imem.Imem_Ready;
  assign pc_next = pc_q + PC_WIDTH'(PC_INCR);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    buf_d        = buf_q;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    fetch_bubble = 1'b0;
    ifid_instr   = imem.Imem_Data;
    unique case (state_q)
      StFetch: begin
        if (Flush) begin
          if (req_q && !imem.Imem_Ready) begin
            tgt_d   = Branch_Target;
            state_d = StDrain;
          end else begin
            pc_d = Branch_Target;
          end
        end else if (ready) begin
          if (advance) begin
            ifid_load = 1'b1;
            pc_d      = pc_next;
          end else begin
            buf_d   = imem.Imem_Data;
            state_d = StHold;
          end
        end else if (IF_ID_Write) begin
          ifid_bubble  = 1'b1;
          fetch_bubble = req_q;
        end
      end
      StHold: begin
        if (Flush) begin
          pc_d    = Branch_Target;
          state_d = StFetch;
        end else if (advance) begin
          ifid_load  = 1'b1;
          ifid_instr = buf_q;
          pc_d       = pc_next;
          state_d    = StFetch;
        end
      end
      StDrain: begin
        // Outstanding request to the old path completes and is thrown away.
        ifid_bubble = 1'b1;
        if (imem.Imem_Ready) begin
          pc_d    = Flush ? Branch_Target : tgt_q;
          state_d = StFetch;
        end else if (Flush) begin
          tgt_d = Branch_Target;
        end
      end
      default: state_d = StFetch;
    endcase
    req_d = (state_d != StHold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      buf_q   <= INSTR_WIDTH'(NOP_INSTR);
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      buf_q   <= buf_d;
      req_q   <= req_d;
    end
  end

  // PC is not updated while a request is pending, so it doubles as the held address.
  assign imem.Imem_Req  = req_q;
  assign imem.Imem_Addr = pc_q;
  assign Fetch_Busy     = req_q & ~imem.Imem_Ready;

  if_fetch_stage_if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ifid_load),
    .bubble      (ifid_bubble),
    .flush       (Flush),
    .pc          (pc_q),
    .instr       (ifid_instr),
    .IF_ID_PC    (IF_ID_PC),
    .IF_ID_Instr (IF_ID_Instr),
    .IF_ID_Valid (IF_ID_Valid)
  );

`ifdef IF_FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (!advance && !Flush && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (fetch_bubble && bubble_cnt_q != '1) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign Stall_Cycles  = stall_cnt_q;
  assign Bubble_Cycles = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: scoreboard of expected IF/ID entries plus directed checks.
module tb_if_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_failed = 0;

  // Memory contents are a fixed function of address, never zero.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return 32'hC000_0000 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // DUT 0: RESET_PC = 0
  logic        rst0_n = 1'b0;
  logic        pw0 = 1'b1, iw0 = 1'b1, fl0 = 1'b0, rdy0 = 1'b1;
  logic [31:0] bt0 = '0;
  logic [31:0] pc0, instr0;
  logic        valid0, busy0;
`ifdef IF_FETCH_STALL_CNT_EN
  logic [31:0] stall0, bub0;
`endif

  if_fetch_stage_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) imem0 ();
  assign imem0.Imem_Ready = rdy0;
  assign imem0.Imem_Data  = mem_f(imem0.Imem_Addr);

  if_fetch_stage #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0000_0000)
  ) dut0 (
    .clk           (clk),
    .rst_n         (rst0_n),
    .PC_Write      (pw0),
    .IF_ID_Write   (iw0),
    .Flush         (fl0),
    .Branch_Target (bt0),
    .imem          (imem0),
    .IF_ID_PC      (pc0),
    .IF_ID_Instr   (instr0),
    .IF_ID_Valid   (valid0),
`ifdef IF_FETCH_STALL_CNT_EN
    .Stall_Cycles  (stall0),
    .Bubble_Cycles (bub0),
`endif
    .Fetch_Busy    (busy0)
  );

  // DUT 1: RESET_PC = 0xFFFF_FFFC, zero-wait memory
  logic        rst1_n = 1'b0;
  logic        pw1 = 1'b1, iw1 = 1'b1;
  logic [31:0] pc1, instr1;
  logic        valid1, busy1;
`ifdef IF_FETCH_STALL_CNT_EN
  logic [31:0] stall1, bub1;
`endif

  if_fetch_stage_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) imem1 ();
  assign imem1.Imem_Ready = 1'b1;
  assign imem1.Imem_Data  = mem_f(imem1.Imem_Addr);

  if_fetch_stage #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'hFFFF_FFFC)
  ) dut1 (
    .clk           (clk),
    .rst_n         (rst1_n),
    .PC_Write      (pw1),
    .IF_ID_Write   (iw1),
    .Flush         (1'b0),
    .Branch_Target (32'h0),
    .imem          (imem1),
    .IF_ID_PC      (pc1),
    .IF_ID_Instr   (instr1),
    .IF_ID_Valid   (valid1),
`ifdef IF_FETCH_STALL_CNT_EN
    .Stall_Cycles  (stall1),
    .Bubble_Cycles (bub1),
`endif
    .Fetch_Busy    (busy1)
  );

  logic [31:0] exp_q[$];

  // One clock; afterwards pop the scoreboard if an advancing edge produced a valid entry.
  task automatic cyc();
    logic adv_prev;
    adv_prev = pw0 & iw0 & ~fl0 & rst0_n;
    @(posedge clk);
    #1;
    if (adv_prev && valid0) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_valid", pc0, 32'hDEAD_DEAD);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check_eq("sb_pc", pc0, e);
        check_eq("sb_instr", instr0, mem_f(e));
      end
    end
  endtask

  initial begin
    #1;
    check_eq("rst_req", {31'b0, imem0.Imem_Req}, 32'd0);
    check_eq("rst_valid", {31'b0, valid0}, 32'd0);
    check_eq("rst_pc", pc0, 32'd0);
    check_eq("rst_instr", instr0, 32'd0);
    cyc(); cyc();
    rst0_n = 1'b1;
    cyc();
    // Back-to-back zero-wait fetches
    check_eq("req_after_rst", {31'b0, imem0.Imem_Req}, 32'd1);
    check_eq("addr0", imem0.Imem_Addr, 32'h0);
    check_eq("busy_zero_wait", {31'b0, busy0}, 32'd0);
    exp_q.push_back(32'h0); cyc();
    check_eq("addr4", imem0.Imem_Addr, 32'h4);
    exp_q.push_back(32'h4); cyc();
    check_eq("addr8", imem0.Imem_Addr, 32'h8);
    // Load-use stall while addr 8 completes
    pw0 = 1'b0; iw0 = 1'b0; cyc();
    check_eq("hold_req", {31'b0, imem0.Imem_Req}, 32'd0);
    check_eq("hold_ifid_pc", pc0, 32'h4);
    check_eq("hold_ifid_valid", {31'b0, valid0}, 32'd1);
    pw0 = 1'b1; iw0 = 1'b1; rdy0 = 1'b0;
    exp_q.push_back(32'h8); cyc();
    check_eq("after_hold_addr", imem0.Imem_Addr, 32'hC);
    check_eq("after_hold_req", {31'b0, imem0.Imem_Req}, 32'd1);
    rdy0 = 1'b1;
    exp_q.push_back(32'hC); cyc();
    check_eq("addr10", imem0.Imem_Addr, 32'h10);
    // Slow memory: two wait cycles on 0x10
    rdy0 = 1'b0; #1;
    check_eq("busy_wait", {31'b0, busy0}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_eq("wait_valid", {31'b0, valid0}, 32'd0);
      check_eq("wait_instr", instr0, 32'd0);
      check_eq("wait_addr", imem0.Imem_Addr, 32'h10);
      check_eq("wait_busy", {31'b0, busy0}, 32'd1);
    end
    rdy0 = 1'b1;
    exp_q.push_back(32'h10); cyc();
    exp_q.push_back(32'h14); cyc();
    exp_q.push_back(32'h18); cyc();
    exp_q.push_back(32'h1C); cyc();
    check_eq("addr20", imem0.Imem_Addr, 32'h20);
    // Flush while the request to 0x20 is pending
    rdy0 = 1'b0; fl0 = 1'b1; bt0 = 32'h100; cyc();
    check_eq("drain_req", {31'b0, imem0.Imem_Req}, 32'd1);
    check_eq("drain_addr", imem0.Imem_Addr, 32'h20);
    check_eq("drain_valid", {31'b0, valid0}, 32'd0);
    fl0 = 1'b0; cyc();
    check_eq("drain_addr2", imem0.Imem_Addr, 32'h20);
    check_eq("drain_valid2", {31'b0, valid0}, 32'd0);
    rdy0 = 1'b1; cyc();
    check_eq("drain_dropped", {31'b0, valid0}, 32'd0);
    check_eq("redirect_addr", imem0.Imem_Addr, 32'h100);
    exp_q.push_back(32'h100); cyc();
    check_eq("addr104", imem0.Imem_Addr, 32'h104);
    // Flush and stall together: flush wins
    pw0 = 1'b0; iw0 = 1'b0; fl0 = 1'b1; bt0 = 32'h200; cyc();
    check_eq("flush_stall_valid", {31'b0, valid0}, 32'd0);
    check_eq("flush_stall_addr", imem0.Imem_Addr, 32'h200);
    check_eq("flush_stall_req", {31'b0, imem0.Imem_Req}, 32'd1);
    pw0 = 1'b1; iw0 = 1'b1; fl0 = 1'b0;
    exp_q.push_back(32'h200); cyc();
    check_eq("addr204", imem0.Imem_Addr, 32'h204);
    check_eq("sb_drained", exp_q.size(), 32'd0);
`ifdef IF_FETCH_STALL_CNT_EN
    check_eq("stall_cnt0", stall0, 32'd1);
    check_eq("bubble_cnt0", bub0, 32'd2);
`endif

    // PC wrap on second DUT
    rst1_n = 1'b1;
    @(posedge clk); #1;
    check_eq("wrap_addr0", imem1.Imem_Addr, 32'hFFFF_FFFC);
    check_eq("wrap_req", {31'b0, imem1.Imem_Req}, 32'd1);
    @(posedge clk); #1;
    check_eq("wrap_addr1", imem1.Imem_Addr, 32'h0);
    check_eq("wrap_ifid_pc", pc1, 32'hFFFF_FFFC);
    check_eq("wrap_ifid_instr", instr1, mem_f(32'hFFFF_FFFC));
    pw1 = 1'b0; iw1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef IF_FETCH_STALL_CNT_EN
    check_eq("stall_cnt1", stall1, 32'd3);
    check_eq("bubble_cnt1", bub1, 32'd0);
`endif
    check_eq("wrap_stall_hold", pc1, 32'hFFFF_FFFC);
    pw1 = 1'b1; iw1 = 1'b1;
    @(posedge clk); #1;
    check_eq("wrap_ifid_pc2", pc1, 32'h0);
    check_eq("wrap_ifid_instr2", instr1, mem_f(32'h0));
    check_eq("wrap_valid2", {31'b0, valid1}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
